// File: rtl/mii_rx_capture.sv
// mii_rx_capture
//   MII receive-frame capture engine. Watches the PHY RX nibble stream, locks
//   onto preamble/SFD, assembles nibbles into bytes and packs the bytes
//   big-lane-first into a DEPTH x DATA_W buffer. It reports the frame length,
//   error/overflow status and a running frame count, then holds the captured
//   frame until i_rearm.
//
//   Optional feature: define MII_RX_FCS_CHECK_EN to build the CRC-32 residue
//   check that drives o_fcs_ok. When it is undefined, o_fcs_ok is tied low.
//
// Ports
//   enet_rx_clk              RX clock from the PHY; all logic on posedge
//   i_reset                  synchronous, active-high reset
//   enet_rx_dv/er/data       MII receive valid, error and nibble
//   i_arm                    level; a new frame may start only while high
//   i_rearm                  pulse; releases HOLD
//   i_rd_addr / o_rd_data    buffer read port, 1-cycle latency, read-old
//   o_frame_len              bytes after SFD incl. FCS, saturating
//   o_frame_done             1-cycle pulse at end of a captured frame
//   o_busy                   high while in PREAMBLE or DATA
//   o_overflow/o_err/o_fcs_ok  status of the last frame
//   o_frame_cnt              completed frames since reset, wrapping
module mii_rx_capture #(
  parameter  int DATA_W    = 32,
  parameter  int DEPTH     = 256,
  parameter  int LSN_FIRST = 1,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              enet_rx_clk,
  input  logic              i_reset,
  input  logic              enet_rx_dv,
  input  logic              enet_rx_er,
  input  logic [3:0]        enet_rx_data,
  input  logic              i_arm,
  input  logic              i_rearm,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [15:0]       o_frame_len,
  output logic              o_frame_done,
  output logic              o_busy,
  output logic              o_overflow,
  output logic              o_err,
  output logic              o_fcs_ok,
  output logic [15:0]       o_frame_cnt
);

  localparam int BPW    = DATA_W / 8;
  localparam int WIDX_W = ADDR_W + 1;  // one extra bit so "index == DEPTH" means full

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_HOLD, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic                last_dv_q;
  logic                phase_q, phase_d;     // 1: low-order nibble of the byte already held
  logic [3:0]          lo_nib_q, lo_nib_d;
  logic                seen5_q, seen5_d;
  logic [3:0]          lane_q, lane_d;       // next lane to fill, 0 = MSB lane
  logic [WIDX_W-1:0]   widx_q, widx_d;       // word index, saturates at DEPTH
  logic [DATA_W-1:0]   word_q, word_d;
  logic [15:0]         byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic [15:0]         frame_len_q, frame_len_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;
  logic [15:0]         cnt_q, cnt_d;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [7:0]          new_byte;
  logic                wfull;

  logic [DATA_W-1:0]   mem [DEPTH];

`ifdef MII_RX_FCS_CHECK_EN
  // Shift-right (reflected) register; the C704DD7B residue appears bit-reversed.
  localparam logic [31:0] RESIDUE_REFL = 32'hDEBB20E3;
  logic [31:0] crc_q, crc_d;
  logic        fcs_ok_q, fcs_ok_d;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    lo_nib_d    = lo_nib_q;
    seen5_d     = seen5_q;
    lane_d      = lane_q;
    widx_d      = widx_q;
    word_d      = word_q;
    byte_cnt_d  = byte_cnt_q;
    frame_len_d = frame_len_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    mem_we      = 1'b0;
    mem_waddr   = widx_q[ADDR_W-1:0];
    mem_wdata   = word_q;
`ifdef MII_RX_FCS_CHECK_EN
    crc_d       = crc_q;
    fcs_ok_d    = fcs_ok_q;
`endif
    new_byte = (LSN_FIRST != 0) ? {enet_rx_data, lo_nib_q} : {lo_nib_q, enet_rx_data};
    wfull    = (widx_q == WIDX_W'(DEPTH));

    case (state_q)
      S_IDLE: begin
        // dv already high on a previous cycle: we joined mid-frame, skip it.
        if (enet_rx_dv && last_dv_q) begin
          state_d = S_DRAIN;
        end else if (enet_rx_dv && i_arm) begin
          state_d    = S_PRE;
          seen5_d    = (enet_rx_data == 4'h5);
          phase_d    = 1'b0;
          lane_d     = '0;
          widx_d     = '0;
          word_d     = '0;
          byte_cnt_d = '0;
          err_d      = 1'b0;
          ovf_d      = 1'b0;
`ifdef MII_RX_FCS_CHECK_EN
          crc_d      = '1;
          fcs_ok_d   = 1'b0;
`endif
        end
      end

      S_PRE: begin
        if (!enet_rx_dv) begin
          state_d = S_IDLE;
        end else if (enet_rx_data == 4'h5) begin
          seen5_d = 1'b1;
        end else if (enet_rx_data == 4'hD && seen5_q) begin
          state_d = S_DATA;
          phase_d = 1'b0;
        end else begin
          err_d   = 1'b1;
          state_d = S_DRAIN;
        end
      end

      S_DATA: begin
        if (enet_rx_er) err_d = 1'b1;
        if (enet_rx_dv) begin
          if (!phase_q) begin
            lo_nib_d = enet_rx_data;
            phase_d  = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (byte_cnt_q != 16'hFFFF) byte_cnt_d = byte_cnt_q + 16'd1;
`ifdef MII_RX_FCS_CHECK_EN
            crc_d = crc_byte(crc_q, new_byte);
`endif
            if (wfull) begin
              ovf_d = 1'b1;
            end else begin
              word_d = word_q | (DATA_W'(new_byte) << ((BPW - 1 - int'(lane_q)) * 8));
              if (lane_q == 4'(BPW - 1)) begin
                mem_we    = 1'b1;
                mem_wdata = word_d;
                word_d    = '0;
                lane_d    = '0;
                widx_d    = widx_q + 1'b1;
              end else begin
                lane_d = lane_q + 4'd1;
              end
            end
          end
        end else begin
          // Dribble nibble: flag it; the half byte never reached the buffer.
          if (phase_q) err_d = 1'b1;
          // Flush a partly filled word; unused lanes are still zero.
          if (lane_q != 4'd0 && !wfull) mem_we = 1'b1;
          frame_len_d = byte_cnt_q;
          done_d      = 1'b1;
          cnt_d       = cnt_q + 16'd1;
          state_d     = S_HOLD;
`ifdef MII_RX_FCS_CHECK_EN
          fcs_ok_d    = (crc_q == RESIDUE_REFL) && !err_d;
`endif
        end
      end

      S_HOLD:  if (i_rearm) state_d = S_IDLE;
      S_DRAIN: if (!enet_rx_dv) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_PRE) || (state_d == S_DATA);
  end

  always_ff @(posedge enet_rx_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      last_dv_q   <= 1'b0;
      phase_q     <= 1'b0;
      lo_nib_q    <= '0;
      seen5_q     <= 1'b0;
      lane_q      <= '0;
      widx_q      <= '0;
      word_q      <= '0;
      byte_cnt_q  <= '0;
      rd_data_q   <= '0;
      frame_len_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
`ifdef MII_RX_FCS_CHECK_EN
      crc_q       <= '1;
      fcs_ok_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_dv_q   <= enet_rx_dv;
      phase_q     <= phase_d;
      lo_nib_q    <= lo_nib_d;
      seen5_q     <= seen5_d;
      lane_q      <= lane_d;
      widx_q      <= widx_d;
      word_q      <= word_d;
      byte_cnt_q  <= byte_cnt_d;
      rd_data_q   <= mem[i_rd_addr];
      frame_len_q <= frame_len_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
`ifdef MII_RX_FCS_CHECK_EN
      crc_q       <= crc_d;
      fcs_ok_q    <= fcs_ok_d;
`endif
    end
  end

  // Buffer RAM: not reset; read above samples the pre-write contents.
  always_ff @(posedge enet_rx_clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign o_rd_data    = rd_data_q;
  assign o_frame_len  = frame_len_q;
  assign o_frame_done = done_q;
  assign o_busy       = busy_q;
  assign o_overflow   = ovf_q;
  assign o_err        = err_q;
  assign o_frame_cnt  = cnt_q;
`ifdef MII_RX_FCS_CHECK_EN
  assign o_fcs_ok     = fcs_ok_q;
`else
  assign o_fcs_ok     = 1'b0;
`endif

endmodule
